// File: rtl/riscv_lsu.sv
// riscv_lsu -- multi-cycle load/store unit.
//
// Takes the ALU effective address, the decoder's width/direction controls and
// the store data. It then runs a single request/ready transaction on the data
// bus and returns the sign- or zero-extended load value. The core is stalled
// through `busy` while the access is outstanding. Misaligned accesses,
// illegal widths and bus timeouts finish through the same one-cycle `done`
// pulse, with `fault` set.
//
// Ports:
//   clk, rst_n           core clock, asynchronous active-low reset
//   start                access request (mem_read | mem_write)
//   is_store             1 = store, 0 = load
//   funct3               width/signedness code (instr[14:12])
//   addr                 effective byte address
//   wdata                store data (rs2)
//   busy                 combinational stall request
//   done                 one-cycle completion pulse
//   rdata                extended load result (valid with done, held after)
//   fault, fault_cause   failure flag / cause: 0 none, 1 misaligned,
//                        2 timeout, 3 illegal width
//   mem_req, mem_we      bus request and write strobe
//   mem_addr             word-aligned bus address
//   mem_wdata, mem_be    lane-replicated store data and byte enables
//   mem_ready            bus handshake (ignored while mem_req = 0)
//   mem_rdata            bus read word
module riscv_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_MISALGN = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state, state_nxt;

  logic             legal;
  logic             aligned;
  logic [3:0]       be_p0;
  logic [31:0]      wdata_p0;
  logic [1:0]       off_p1;
  logic [2:0]       funct3_p1;
  logic [CNT_W-1:0] wait_cnt_p1;
  logic             timeout_hit;

  // Lane select and extension of a bus word. The offset and width come from
  // the registered request, because the core's inputs move on while the
  // access is outstanding.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [31:0]        shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    shifted = word >> {off, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = shifted[15:0];
    case (f3)
      3'd0:    load_extend = 32'(byte_s);
      3'd1:    load_extend = 32'(half_s);
      3'd4:    load_extend = {24'b0, shifted[7:0]};
      3'd5:    load_extend = {16'b0, shifted[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  // Request decode (combinational, from the core's current inputs)
  always_comb begin
    legal    = 1'b0;
    aligned  = 1'b1;
    be_p0    = 4'b1111;
    wdata_p0 = wdata;
    case (funct3)
      3'd0, 3'd1, 3'd2: legal = 1'b1;
      3'd4, 3'd5:       legal = !is_store;
      default:          legal = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00: begin
        be_p0    = 4'b0001 << addr[1:0];
        wdata_p0 = {4{wdata[7:0]}};
      end
      2'b01: begin
        aligned  = !addr[0];
        be_p0    = 4'b0011 << {addr[1], 1'b0};
        wdata_p0 = {2{wdata[15:0]}};
      end
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  // The TIMEOUT-th REQ cycle is the one where the counter reads TIMEOUT-1.
  assign timeout_hit = (wait_cnt_p1 == CNT_W'(TIMEOUT - 1));

  assign busy = ((state == IDLE) && start) || (state == REQ);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (legal && aligned) ? REQ : DONE;
      REQ:  if (mem_ready || timeout_hit) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture / response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      off_p1      <= '0;
      funct3_p1   <= '0;
      wait_cnt_p1 <= '0;
      rdata       <= '0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (legal && aligned) begin
              mem_req     <= 1'b1;
              mem_we      <= is_store;
              mem_addr    <= {addr[31:2], 2'b00};
              mem_wdata   <= wdata_p0;
              mem_be      <= be_p0;
              off_p1      <= addr[1:0];
              funct3_p1   <= funct3;
              wait_cnt_p1 <= '0;
            end else begin
              rdata       <= '0;
              fault       <= 1'b1;
              fault_cause <= legal ? CAUSE_MISALGN : CAUSE_ILLEGAL;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_req     <= 1'b0;
            rdata       <= mem_we ? 32'b0 : load_extend(mem_rdata, off_p1, funct3_p1);
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
          end else if (timeout_hit) begin
            mem_req     <= 1'b0;
            rdata       <= '0;
            fault       <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
          end else if (wait_cnt_p1 != CNT_W'(TIMEOUT)) begin
            wait_cnt_p1 <= wait_cnt_p1 + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu with a transaction-level expectation model.
module tb_riscv_lsu;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, fault, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [1:0]  fault_cause;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  riscv_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .fault(fault), .fault_cause(fault_cause),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected transaction, set by the driver, checked by the compare process.
  logic        m_active = 1'b0;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic        m_fault, m_chk_rdata;
  logic [1:0]  m_cause;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [1:0] exp_cause(input logic st, input logic [2:0] f3,
                                           input logic [31:0] a);
    bit ok;
    ok = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!ok) return 2'd3;
    if ((a % nbytes(f3)) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    logic [7:0] m;
    m = ((8'd1 << nbytes(f3)) - 8'd1) << a[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int nb;
    nb = nbytes(f3);
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    longint v;
    int nb;
    nb = nbytes(f3);
    v = longint'(rd) >> (8 * a[1:0]);
    if (nb < 4) begin
      v = v & ((longint'(1) << (8 * nb)) - 1);
      if (!f3[2] && (((v >> (8 * nb - 1)) & 1) == 1)) v = v - (longint'(1) << (8 * nb));
    end
    return v[31:0];
  endfunction

  // Compare process: bus fields whenever a request is up, results on done.
  always @(negedge clk) begin
    if (m_active && rst_n) begin
      if (mem_req) begin
        chk("bus_addr", mem_addr, m_addr);
        chk("bus_be", 32'(mem_be), 32'(m_be));
        chk("bus_wdata", mem_wdata, m_wdata);
        chk("bus_we", 32'(mem_we), 32'(m_we));
      end
      if (done) begin
        chk("fault", 32'(fault), 32'(m_fault));
        chk("fault_cause", 32'(fault_cause), 32'(m_cause));
        if (m_chk_rdata) chk("rdata", rdata, m_rdata);
      end
    end
  end

  // Runs one access starting in the current IDLE cycle (called #1 after an
  // edge). waits < 0 means mem_ready is never given. Returns #1 after the
  // edge following the done cycle, i.e. in the next IDLE cycle.
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits,
                        output logic [3:0] be_s, output logic [31:0] wd_s,
                        output logic [31:0] rd_g, output logic [1:0] cause_g);
    logic [1:0] c;
    bit to;
    int lat, reqs, exp_lat, exp_reqs;
    c  = exp_cause(st, f3, a);
    to = (c == 2'd0) && (waits < 0 || waits >= TO);
    m_we        = st;
    m_addr      = {a[31:2], 2'b00};
    m_be        = exp_be(f3, a);
    m_wdata     = exp_wdata(f3, wd);
    m_cause     = to ? 2'd2 : c;
    m_fault     = (m_cause != 2'd0);
    m_chk_rdata = (c == 2'd0);
    m_rdata     = (to || st) ? 32'd0 : exp_load(f3, a, rd);
    exp_lat     = (c != 0) ? 1 : (to ? TO + 1 : waits + 2);
    exp_reqs    = (c != 0) ? 0 : (to ? TO : waits + 1);
    m_active    = 1'b1;
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    mem_rdata = rd; mem_ready = 1'b0;
    #1 chk("busy_start", 32'(busy), 32'd1);
    @(posedge clk); #1;
    start = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0; funct3 = 3'd7;
    lat = 1; reqs = 0; be_s = '0; wd_s = '0;
    while (done !== 1'b1 && lat < 64) begin
      if (mem_req === 1'b1) begin
        reqs++;
        if (reqs == 1) begin be_s = mem_be; wd_s = mem_wdata; end
        chk("busy_req", 32'(busy), 32'd1);
        mem_ready = (waits >= 0 && reqs > waits);
      end else begin
        mem_ready = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    mem_ready = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    rd_g = rdata; cause_g = fault_cause;
    chk("busy_done", 32'(busy), 32'd0);
    chk("req_at_done", 32'(mem_req), 32'd0);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("req_cycles", 32'(reqs), 32'(exp_reqs));
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("cause_held", 32'(fault_cause), 32'(m_cause));
    m_active = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  be_s;
    logic [31:0] wd_s, rd_g;
    logic [1:0]  cause_g;

    // Reset state
    #12;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cause", 32'(fault_cause), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // mem_ready while idle must not start or finish anything
    mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready_req", 32'(mem_req), 32'd0);
    chk("idle_ready_done", 32'(done), 32'd0);
    mem_ready = 1'b0;

    // LW aligned, ready in the first REQ cycle
    access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, be_s, wd_s, rd_g, cause_g);
    chk("lw_rdata_lit", rd_g, 32'hDEADBEEF);
    chk("lw_be_lit", 32'(be_s), 32'hF);

    // LB / LBU lane extraction from the top byte
    access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 0, be_s, wd_s, rd_g, cause_g);
    chk("lb_rdata_lit", rd_g, 32'hFFFF_FF80);
    chk("lb_be_lit", 32'(be_s), 32'h8);
    access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 0, be_s, wd_s, rd_g, cause_g);
    chk("lbu_rdata_lit", rd_g, 32'h0000_0080);

    // SH with three wait cycles
    access(1'b1, 3'd1, 32'h22, 32'h1234_ABCD, 32'h5555_5555, 3, be_s, wd_s, rd_g, cause_g);
    chk("sh_be_lit", 32'(be_s), 32'hC);
    chk("sh_wdata_lit", wd_s, 32'hABCD_ABCD);
    chk("sh_rdata_lit", rd_g, 32'h0);

    // Halfword loads, both lanes, both signedness
    access(1'b0, 3'd1, 32'h202, 32'h0, 32'h8001_1234, 1, be_s, wd_s, rd_g, cause_g);
    chk("lh_rdata_lit", rd_g, 32'hFFFF_8001);
    access(1'b0, 3'd5, 32'h200, 32'h0, 32'h8001_F234, 0, be_s, wd_s, rd_g, cause_g);
    chk("lhu_rdata_lit", rd_g, 32'h0000_F234);
    access(1'b0, 3'd2, 32'h300, 32'h0, 32'h0123_4567, 2, be_s, wd_s, rd_g, cause_g);

    // SB lane replication
    access(1'b1, 3'd0, 32'h41, 32'h1122_3355, 32'h0, 0, be_s, wd_s, rd_g, cause_g);
    chk("sb_wdata_lit", wd_s, 32'h5555_5555);
    chk("sb_be_lit", 32'(be_s), 32'h2);
    access(1'b1, 3'd2, 32'h44, 32'hCAFE_F00D, 32'h0, 0, be_s, wd_s, rd_g, cause_g);

    // Faults: misaligned, illegal store width, illegal beats misaligned
    access(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0, be_s, wd_s, rd_g, cause_g);
    chk("misalign_cause_lit", 32'(cause_g), 32'd1);
    access(1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 0, be_s, wd_s, rd_g, cause_g);
    chk("illegal_cause_lit", 32'(cause_g), 32'd3);
    access(1'b0, 3'd3, 32'h101, 32'h0, 32'h0, 0, be_s, wd_s, rd_g, cause_g);
    chk("illegal_prio_lit", 32'(cause_g), 32'd3);
    access(1'b0, 3'd1, 32'h105, 32'h0, 32'h0, 0, be_s, wd_s, rd_g, cause_g);

    // Timeout, then a normal access right behind it
    access(1'b0, 3'd2, 32'h400, 32'h0, 32'h1111_1111, -1, be_s, wd_s, rd_g, cause_g);
    chk("timeout_cause_lit", 32'(cause_g), 32'd2);
    chk("timeout_rdata_lit", rd_g, 32'h0);
    access(1'b0, 3'd2, 32'h404, 32'h0, 32'h2222_3333, 0, be_s, wd_s, rd_g, cause_g);
    chk("after_to_rdata_lit", rd_g, 32'h2222_3333);

    // Reset in the middle of a stalled load
    start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h500; mem_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("mid_req_up", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_req_drop", 32'(mem_req), 32'd0);
    chk("async_no_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("rst_hold_done", 32'(done), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    access(1'b0, 3'd2, 32'h600, 32'h0, 32'h7654_3210, 0, be_s, wd_s, rd_g, cause_g);
    chk("post_rst_lw_lit", rd_g, 32'h7654_3210);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Multi-cycle load/store unit for the RISC-V core, sitting directly downstream of `riscv_alu` and `riscv_decoder`. It takes the ALU effective address, the decoder's memory controls, and `rs2` store data. It then runs one request/ready transaction on the data bus and returns a sign- or zero-extended load value to the writeback mux. It stalls the core while the access is outstanding and flags misaligned, illegal-width and timed-out accesses.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum number of bus cycles with `mem_req` high and no `mem_ready` before the access is aborted. Must be ≥1.

Ports:
- `clk` in 1: core clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: access request, from decoder `mem_read | mem_write`.
- `is_store` in 1: 1 = store, 0 = load.
- `funct3` in 3: access width and signedness (instruction bits 14:12).
- `addr` in 32: effective byte address (ALU result).
- `wdata` in 32: store data (`rs2_data`).
- `busy` out 1: stall request to the core (PC/regfile write enable held off).
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load result; valid while `done`=1.
- `fault` out 1: access failed; valid while `done`=1.
- `fault_cause` out 2: 0 none, 1 misaligned, 2 timeout, 3 illegal width.
- `mem_req` out 1: bus request.
- `mem_we` out 1: bus write strobe.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_be` out 4: byte enables.
- `mem_ready` in 1: bus accepted the write, or read data is valid.
- `mem_rdata` in 32: bus read word.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE + `start` + legal + aligned → REQ. The unit registers `mem_addr`, `mem_we`=`is_store`, `mem_be`, `mem_wdata`, the byte offset and `funct3`, and sets `mem_req`=1.
- IDLE + `start` + (illegal or misaligned) → DONE with `fault`=1. No bus request is issued.
- REQ + `mem_ready`: capture the extended load data (0 for stores), drop `mem_req`, go to DONE with `fault_cause`=0.
- REQ + no `mem_ready` on the TIMEOUT-th REQ cycle: drop `mem_req`, go to DONE with `rdata`=0 and `fault_cause`=2.
- DONE → IDLE unconditionally. `start` is ignored in REQ and DONE.
- Width decode:
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
  - Every other code is illegal (cause 3). Cause 3 takes priority over cause 1.
- Alignment:
  - Halfword requires `addr[0]`=0.
  - Word requires `addr[1:0]`=0.
  - Byte accesses are always aligned.
- `mem_be`:
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `4'b0011 << {addr[1],1'b0}`.
  - Word: `4'b1111`.
  - Loads drive the same enables as stores.
- `mem_wdata`:
  - SB: `{4{wdata[7:0]}}`.
  - SH: `{2{wdata[15:0]}}`.
  - SW: `wdata`.
- Load extraction:
  - Select the byte or halfword lane by the registered offset.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- Timeout counter:
  - Cleared on entry to REQ; increments each REQ cycle without `mem_ready`.
  - Width `$clog2(TIMEOUT+1)`; saturates and never wraps.
- `busy` = (IDLE & `start`) | REQ. It is combinational so the core stalls in the same cycle `start` rises. It is 0 in DONE, so the core advances on the `done` cycle.

## Timing
- Reset (async, `rst_n`=0): state IDLE. `mem_req`, `mem_we`, `done`, `fault`, `busy`(registered part), `fault_cause`, `rdata`, `mem_addr`, `mem_wdata`, `mem_be` are all 0.
- Reset mid-access drops `mem_req` immediately (not at the next edge); the pending transaction is discarded and no `done` is produced.
- Latency:
  - Bus `mem_ready` in the first REQ cycle gives `start` at cycle N, `mem_req` at N+1, `done` at N+2.
  - Each wait cycle adds one cycle.
  - Fault paths (misaligned/illegal): `done` at N+1, `mem_req` never asserted.
  - Timeout: `mem_req` high for exactly TIMEOUT cycles, `done` in the following cycle.
- `mem_addr`, `mem_we`, `mem_be`, `mem_wdata` are stable for the whole time `mem_req`=1.
- `mem_ready` is ignored when `mem_req`=0.
- `done` is high for exactly one cycle. `rdata`, `fault` and `fault_cause` hold their values until the next `done`.
- Back-to-back accesses: the next `start` is accepted in the IDLE cycle after DONE, giving a minimum of 2 cycles between `done` pulses.

## Test plan
- LW aligned: `addr`=0x100, `mem_rdata`=0xDEADBEEF, `mem_ready` in the first REQ cycle → `mem_addr`=0x100, `mem_be`=0xF, `mem_we`=0, `done` at N+2, `rdata`=0xDEADBEEF, `fault`=0.
- LB/LBU lane extract: `addr`=0x103, `mem_rdata`=0x80FF_0000 → LB gives `rdata`=0xFFFFFF80, LBU gives 0x00000080, `mem_be`=0x8.
- SH with 3 wait cycles: `addr`=0x22, `wdata`=0x1234ABCD → `mem_be`=0xC, `mem_wdata`=0xABCDABCD, `mem_we`=1; `mem_req` high 4 cycles, `done` 5 cycles after `start`, `busy`=1 throughout.
- Faults:
  - LW at `addr`=0x102 → `done` at N+1 with `fault_cause`=1 and `mem_req` never asserted.
  - Store with `funct3`=4 → `fault_cause`=3.
- Timeout: TIMEOUT=16, `mem_ready` held 0 → `mem_req` high exactly 16 cycles, then `done`, `fault_cause`=2, `rdata`=0; the next access completes normally.
- Reset mid-REQ: deassert `rst_n` 2 cycles into a load → `mem_req` falls asynchronously, no `done` pulse. After release, a new LW completes in 2 cycles.
